// File: rtl/ctech_lib_clk_req_pkg.sv
// Clock-request OR: shared types and legal ranges.
// Used by the request FSM and the clock gate.
package ctech_lib_clk_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } clk_req_st_e;

  localparam int NUM_CH_MIN   = 2;
  localparam int NUM_CH_MAX   = 32;
  localparam int WAKE_CYC_MIN = 1;
  localparam int WAKE_CYC_MAX = 15;
  localparam int HOLD_W_MIN   = 1;
  localparam int HOLD_W_MAX   = 16;

  // Counter must hold both WAKE_CYC-1 and hold_cnt-1.
  function automatic int cnt_width(input int hold_w);
    return (hold_w > 4) ? hold_w : 4;
  endfunction

endpackage

// File: rtl/ctech_lib_clk_gate_lat.sv
// Latch-based clock gate; enable is captured while clk is low.
// Reset closes the latch so clkout drops at once.
module ctech_lib_clk_gate_lat
  import ctech_lib_clk_req_pkg::*;
(
  input  logic clk,
  input  logic en,
  input  logic rst_b,
  output logic clkout
);

  logic en_lat;

  // Transparent in the low phase, so a high phase is never cut short.
  always_latch begin
    if (!rst_b) begin
      en_lat = 1'b0;
    end else if (!clk) begin
      en_lat = en;
    end
  end

  assign clkout = clk & en_lat;

endmodule

// File: rtl/ctech_lib_clk_req_or.sv
// ORs per-channel clock requests into one gated clock.
// IDLE -> WAKE -> ACTIVE -> HOLD with per-channel acks.
module ctech_lib_clk_req_or
  import ctech_lib_clk_req_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HOLD_W   = 4,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic              force_on,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic [NUM_CH-1:0] ack,
  output logic              clk_en,
  output logic              clkout,
  output logic              busy
);

  localparam int CNT_W = cnt_width(HOLD_W);
  localparam logic [CNT_W-1:0] WAKE_LD =
    CNT_W'(WAKE_CYC - 1);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX)
  begin : g_bad_num_ch
    $fatal(1, "NUM_CH out of range");
  end

  if (WAKE_CYC < WAKE_CYC_MIN || WAKE_CYC > WAKE_CYC_MAX)
  begin : g_bad_wake_cyc
    $fatal(1, "WAKE_CYC out of range");
  end

  if (HOLD_W < HOLD_W_MIN || HOLD_W > HOLD_W_MAX)
  begin : g_bad_hold_w
    $fatal(1, "HOLD_W out of range");
  end

  clk_req_st_e       state;
  clk_req_st_e       state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_CH-1:0] eff;
  logic [NUM_CH-1:0] ack_nxt;
  logic              wake;

  assign eff  = req & ~mask;
  assign wake = (|eff) | force_on;
  assign busy = (state != ST_IDLE);

  // Next state and down-counter; counter never wraps below zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (wake) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = WAKE_LD;
        end
      end
      ST_WAKE: begin
        if (cnt == '0) begin
          state_nxt = ST_ACTIVE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (!wake) begin
          if (hold_cnt != '0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = CNT_W'(hold_cnt) - CNT_W'(1);
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (wake) begin
          state_nxt = ST_ACTIVE;
        end else if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Acks only follow the masked requests while ACTIVE.
  always_comb begin
    ack_nxt = '0;
    if (state_nxt == ST_ACTIVE) begin
      ack_nxt = eff;
    end
  end

  // State, counter, registered enable and acks.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      clk_en <= 1'b0;
      ack    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      clk_en <= (state_nxt != ST_IDLE);
      ack    <= ack_nxt;
    end
  end

  ctech_lib_clk_gate_lat u_gate (
    .clk    (clk),
    .en     (clk_en),
    .rst_b  (rst_b),
    .clkout (clkout)
  );

endmodule

// File: tb/tb_ctech_lib_clk_req_or.sv
// Directed bench for ctech_lib_clk_req_or.
// NUM_CH=4, HOLD_W=4, WAKE_CYC=2.
module tb_ctech_lib_clk_req_or;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] req;
  logic [3:0] mask;
  logic       force_on;
  logic [3:0] hold_cnt;
  logic [3:0] ack;
  logic       clk_en;
  logic       clkout;
  logic       busy;

  int  n_assert  = 0;
  int  n_fail    = 0;
  int  pulse_cnt = 0;
  int  en_cyc    = 0;
  int  glitch    = 0;
  time t_rise    = 0;

  always #5 clk = ~clk;

  ctech_lib_clk_req_or #(
    .NUM_CH   (4),
    .HOLD_W   (4),
    .WAKE_CYC (2)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .req      (req),
    .mask     (mask),
    .force_on (force_on),
    .hold_cnt (hold_cnt),
    .ack      (ack),
    .clk_en   (clk_en),
    .clkout   (clkout),
    .busy     (busy)
  );

  always @(posedge clkout) begin
    pulse_cnt++;
    t_rise = $time;
  end

  always @(negedge clkout) begin
    if (rst_b && ($time - t_rise != 5)) glitch++;
  end

  always @(negedge clk) begin
    if (clk_en === 1'b1) en_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] e_ack,
                         input logic e_en,
                         input logic e_busy);
    check({tag, ".ack"}, 32'(ack), 32'(e_ack));
    check({tag, ".clk_en"}, 32'(clk_en), 32'(e_en));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  initial begin
    rst_b    = 1'b0;
    req      = 4'b0000;
    mask     = 4'b0000;
    force_on = 1'b0;
    hold_cnt = 4'd0;
    step();
    step();
    chk_out("reset", 4'b0000, 1'b0, 1'b0);
    check("reset.clkout", 32'(clkout), 32'd0);
    rst_b = 1'b1;
    step();
    chk_out("idle", 4'b0000, 1'b0, 1'b0);

    // wake-up latency
    req = 4'b0001;
    step();
    chk_out("wake1", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("wake2", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("act1", 4'b0001, 1'b1, 1'b1);
    check("act1.clkout", 32'(clkout), 32'd1);

    // second channel, then masking
    req = 4'b0011;
    step();
    chk_out("req0011", 4'b0011, 1'b1, 1'b1);
    mask = 4'b0001;
    step();
    chk_out("mask0001", 4'b0010, 1'b1, 1'b1);

    // all masked -> HOLD for 3 cycles
    mask     = 4'b0011;
    hold_cnt = 4'd3;
    step();
    chk_out("hold1", 4'b0000, 1'b1, 1'b1);
    hold_cnt = 4'd15;
    step();
    chk_out("hold2", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("hold3", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("hold_exp", 4'b0000, 1'b0, 1'b0);

    // re-wake on channel 2
    mask = 4'b0000;
    req  = 4'b0100;
    step();
    step();
    step();
    chk_out("ch2_act", 4'b0100, 1'b1, 1'b1);

    // HOLD with expiry-cycle re-request
    req      = 4'b0000;
    hold_cnt = 4'd2;
    step();
    chk_out("h2_1", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("h2_2", 4'b0000, 1'b1, 1'b1);
    req = 4'b0100;
    step();
    chk_out("h2_rewake", 4'b0100, 1'b1, 1'b1);

    // asynchronous reset mid-ACTIVE
    rst_b = 1'b0;
    #1;
    chk_out("arst", 4'b0000, 1'b0, 1'b0);
    check("arst.clkout", 32'(clkout), 32'd0);
    step();
    rst_b = 1'b1;
    step();
    chk_out("rwake1", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("rwake2", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("ract", 4'b0100, 1'b1, 1'b1);

    // drop with hold_cnt=0 -> IDLE next cycle
    req      = 4'b0000;
    hold_cnt = 4'd0;
    step();
    chk_out("to_idle", 4'b0000, 1'b0, 1'b0);

    // wake dropping during WAKE is ignored
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    chk_out("wdrop_w2", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("wdrop_act", 4'b0000, 1'b1, 1'b1);
    step();
    chk_out("wdrop_idle", 4'b0000, 1'b0, 1'b0);

    // force_on window: 4 enabled cycles, 4 pulses
    pulse_cnt = 0;
    en_cyc    = 0;
    force_on  = 1'b1;
    step();
    step();
    step();
    chk_out("force_act", 4'b0000, 1'b1, 1'b1);
    step();
    force_on = 1'b0;
    step();
    chk_out("force_idle", 4'b0000, 1'b0, 1'b0);
    step();
    step();
    check("en_cycles", 32'(en_cyc), 32'd4);
    check("pulses", 32'(pulse_cnt), 32'd4);
    check("glitches", 32'(glitch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
